// File: rtl/normalizacion_param.sv
// rtl/normalizacion_param.sv - floating-point mantissa normaliser with carry handling
// Accepts one operand at a time and shifts it one bit per cycle until normalised, denormal, zero or overflowed.
module normalizacion_param #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int CNT_W  = 4
) (
  input  logic              clkNorm,
  input  logic              rstNorm,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_carry,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_shift,
  output logic              out_ovf,
  output logic              out_udf,
  output logic              out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t              state_q, state_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [CNT_W-1:0]    shift_q, shift_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                zero_q, zero_d;

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    shift_d = shift_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d  = in_mant;
          exp_d   = in_exp;
          carry_d = in_carry;
          shift_d = '0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // One action per cycle; the carry is consumed by the first, so a right shift never mixes with left shifts.
        if (carry_q && (exp_q == EXP_MAX)) begin
          mant_d  = '1;
          carry_d = 1'b0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (carry_q) begin
          mant_d  = {1'b1, mant_q[MANT_W-1:1]};
          exp_d   = exp_q + EXP_ONE;
          carry_d = 1'b0;
          state_d = DONE;
        end else if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q <= EXP_ONE) begin
          exp_d   = '0;
          udf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d  = {mant_q[MANT_W-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
          shift_d = shift_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkNorm) begin
    if (rstNorm) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      shift_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_shift = shift_q;
  assign out_ovf   = ovf_q;
  assign out_udf   = udf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_normalizacion_param.sv
// tb/tb_normalizacion_param.sv - directed-vector bench for normalizacion_param
module tb_normalizacion_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_carry;
  logic [9:0] in_mant;
  logic [4:0] in_exp;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_mant;
  logic [4:0] out_exp;
  logic [3:0] out_shift;
  logic       out_ovf, out_udf, out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  normalizacion_param #(.MANT_W(10), .EXP_W(5), .CNT_W(4)) dut (
    .clkNorm  (clk),
    .rstNorm  (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_carry (in_carry),
    .in_mant  (in_mant),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mant (out_mant),
    .out_exp  (out_exp),
    .out_shift(out_shift),
    .out_ovf  (out_ovf),
    .out_udf  (out_udf),
    .out_zero (out_zero)
  );

  typedef struct {
    logic       carry;
    logic [9:0] mant;
    logic [4:0] exp;
    logic [9:0] e_mant;
    logic [4:0] e_exp;
    logic [3:0] e_shift;
    logic       e_ovf;
    logic       e_udf;
    logic       e_zero;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drives one operand, measures latency counting the accept edge as edge 1, checks and consumes the result.
  task automatic run_vec(input vec_t v, input int idx);
    int edges;
    @(negedge clk);
    chk($sformatf("v%0d in_ready_before", idx), int'(in_ready), 1);
    in_valid = 1'b1;
    in_carry = v.carry;
    in_mant  = v.mant;
    in_exp   = v.exp;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk($sformatf("v%0d latency", idx), edges, v.lat);
    chk($sformatf("v%0d mant", idx), int'(out_mant), int'(v.e_mant));
    chk($sformatf("v%0d exp", idx), int'(out_exp), int'(v.e_exp));
    chk($sformatf("v%0d shift", idx), int'(out_shift), int'(v.e_shift));
    chk($sformatf("v%0d ovf", idx), int'(out_ovf), int'(v.e_ovf));
    chk($sformatf("v%0d udf", idx), int'(out_udf), int'(v.e_udf));
    chk($sformatf("v%0d zero", idx), int'(out_zero), int'(v.e_zero));
    chk($sformatf("v%0d in_ready_done", idx), int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d valid_after_consume", idx), int'(out_valid), 0);
    chk($sformatf("v%0d ready_after_consume", idx), int'(in_ready), 1);
    chk($sformatf("v%0d mant_kept", idx), int'(out_mant), int'(v.e_mant));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_ready"}, int'(in_ready), 1);
    chk({tag, "_mant"}, int'(out_mant), 0);
    chk({tag, "_exp"}, int'(out_exp), 0);
    chk({tag, "_shift"}, int'(out_shift), 0);
    chk({tag, "_flags"}, int'({out_ovf, out_udf, out_zero}), 0);
  endtask

  initial begin
    logic [9:0] hold_mant;
    logic [4:0] hold_exp;
    logic [3:0] hold_shift;
    int seen;

    vecs[0]  = '{1'b0, 10'b1000000000, 5'd15, 10'b1000000000, 5'd15, 4'd0, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 10'b0000010110, 5'd15, 10'b1011000000, 5'd10, 4'd5, 1'b0, 1'b0, 1'b0, 7};
    vecs[2]  = '{1'b1, 10'b0110000001, 5'd15, 10'b1011000000, 5'd16, 4'd0, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b1, 10'b0110000001, 5'd31, 10'b1111111111, 5'd31, 4'd0, 1'b1, 1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 10'b0000000011, 5'd3,  10'b0000001100, 5'd0,  4'd2, 1'b0, 1'b1, 1'b0, 4};
    vecs[5]  = '{1'b0, 10'b0000000000, 5'd9,  10'b0000000000, 5'd0,  4'd0, 1'b0, 1'b0, 1'b1, 2};
    vecs[6]  = '{1'b0, 10'b0000000001, 5'd20, 10'b1000000000, 5'd11, 4'd9, 1'b0, 1'b0, 1'b0, 11};
    vecs[7]  = '{1'b0, 10'b0100000000, 5'd1,  10'b0100000000, 5'd0,  4'd0, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{1'b0, 10'b0010000000, 5'd0,  10'b0010000000, 5'd0,  4'd0, 1'b0, 1'b1, 1'b0, 2};
    vecs[9]  = '{1'b1, 10'b1111111111, 5'd30, 10'b1111111111, 5'd31, 4'd0, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b0, 10'b0001000000, 5'd5,  10'b1000000000, 5'd2,  4'd3, 1'b0, 1'b0, 1'b0, 5};
    vecs[11] = '{1'b0, 10'b0000100000, 5'd3,  10'b0010000000, 5'd0,  4'd2, 1'b0, 1'b1, 1'b0, 4};

    rst = 1'b1;
    in_valid = 1'b0;
    in_carry = 1'b0;
    in_mant = '0;
    in_exp = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-pressure: result must hold for 5 cycles and extra operands must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_carry = vecs[1].carry;
    in_mant  = vecs[1].mant;
    in_exp   = vecs[1].exp;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(posedge clk);
      @(negedge clk);
      seen++;
    end
    chk("hold_valid", int'(out_valid), 1);
    hold_mant  = out_mant;
    hold_exp   = out_exp;
    hold_shift = out_shift;
    chk("hold_mant_ref", int'(hold_mant), int'(vecs[1].e_mant));
    in_valid = 1'b1;
    in_carry = 1'b1;
    in_mant  = 10'b0000000001;
    in_exp   = 5'd4;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), int'(out_valid), 1);
      chk($sformatf("hold%0d_ready", c), int'(in_ready), 0);
      chk($sformatf("hold%0d_mant", c), int'(out_mant), int'(vecs[1].e_mant));
      chk($sformatf("hold%0d_exp", c), int'(out_exp), int'(vecs[1].e_exp));
      chk($sformatf("hold%0d_shift", c), int'(out_shift), int'(vecs[1].e_shift));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_valid", int'(out_valid), 0);
    chk("hold_release_ready", int'(in_ready), 1);
    run_vec(vecs[0], 100);

    // Reset in the middle of a multi-cycle normalisation discards the operand.
    @(negedge clk);
    in_valid = 1'b1;
    in_carry = vecs[1].carry;
    in_mant  = vecs[1].mant;
    in_exp   = vecs[1].exp;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale_valid", seen, 0);
    run_vec(vecs[1], 101);

    // Reset wins over a simultaneous in_valid.
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_mant  = 10'b1000000000;
    in_exp   = 5'd7;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_all_zero("rstprio");
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rstprio_no_valid", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
